gray_mon: RTL

- Downstream consumer of the 4-bit up/down Gray counter output.
- Samples the Gray code and decodes it to binary.
- Checks that every change is a legal single-step Gray transition, derives count direction, and accumulates a wrapped position count.
- Flags and counts illegal jumps; serves as a checker/position tracker at the counter output.

---
 rtl/gray_mon.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/gray_mon.sv
// Gray counter checker: decode, step/direction, position and illegal-jump tracking; latency N+1 (N=SYNC_STAGES with GRAY_MON_SYNC_EN defined, else 1).
// No backpressure: gray_in is sampled every cycle and every output is updated every cycle.
module gray_mon #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 8,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

`ifdef GRAY_MON_SYNC_EN
  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
`else
  localparam int N = 1;
`endif

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

  logic [N-1:0][WIDTH-1:0] smp;
  logic [N-1:0]            smp_vld;
  logic [WIDTH-1:0]        s;
  logic [WIDTH-1:0]        b;
  logic [WIDTH-1:0]        ref_bin;
  logic [WIDTH-1:0]        delta;
  logic                    is_up;
  logic                    is_dn;
  logic                    is_bad;
  logic [ERR_W-1:0]        cnt_inc;

  state_t                  state;
  state_t                  state_nxt;
  logic [WIDTH-1:0]        ref_nxt;
  logic [POS_W-1:0]        pos_nxt;
  logic                    dir_nxt;
  logic                    step_nxt;
  logic                    err_nxt;
  logic [ERR_W-1:0]        cnt_nxt;

  // smp_vld marks stages holding real input, so INIT never latches reset-zero as its reference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      smp     <= '0;
      smp_vld <= '0;
    end else begin
      smp[0] <= gray_in;
      for (int i = 1; i < N; i++) begin
        smp[i] <= smp[i-1];
      end
      smp_vld <= (smp_vld << 1) | N'(1);
    end
  end

  assign s = smp[N-1];

  always_comb begin
    b = '0;
    b[WIDTH-1] = s[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ s[i];
    end
  end

  assign delta   = b - ref_bin;
  assign is_up   = (delta == WIDTH'(1));
  assign is_dn   = (delta == '1);
  assign is_bad  = (delta != '0) && !is_up && !is_dn;
  assign cnt_inc = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);

  always_comb begin
    state_nxt = state;
    ref_nxt   = ref_bin;
    pos_nxt   = pos;
    dir_nxt   = dir;
    step_nxt  = 1'b0;
    err_nxt   = err;
    cnt_nxt   = err_cnt;
    if (clr) begin
      state_nxt = INIT;
      pos_nxt   = '0;
      err_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else begin
      case (state)
        INIT: begin
          if (smp_vld[N-1]) begin
            ref_nxt   = b;
            state_nxt = TRACK;
          end
        end
        TRACK: begin
          if (is_up) begin
            step_nxt = 1'b1;
            dir_nxt  = 1'b0;
            pos_nxt  = pos + POS_W'(1);
            ref_nxt  = b;
          end else if (is_dn) begin
            step_nxt = 1'b1;
            dir_nxt  = 1'b1;
            pos_nxt  = pos - POS_W'(1);
            ref_nxt  = b;
          end else if (is_bad) begin
            err_nxt   = 1'b1;
            cnt_nxt   = cnt_inc;
            ref_nxt   = b;
            state_nxt = FAULT;
          end
        end
        FAULT: begin
          ref_nxt = b;
          if (is_bad) begin
            cnt_nxt = cnt_inc;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      ref_bin <= '0;
      bin_out <= '0;
      step    <= 1'b0;
      dir     <= 1'b0;
      pos     <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ref_bin <= ref_nxt;
      bin_out <= b;
      step    <= step_nxt;
      dir     <= dir_nxt;
      pos     <= pos_nxt;
      err     <= err_nxt;
      err_cnt <= cnt_nxt;
    end
  end

endmodule
